// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/LSU/memory signal bundle for mem_port_arbiter
//
// Signals:
//   flush_ip                         pipeline flush (taken branch/jump)
//   if_req/addr_ip                   fetch request; if_gnt/rvalid/rdata/stall_op back
//   lsu_req/we/be/addr/wdata_ip      load/store request; lsu_gnt/rvalid/rdata/stall_op back
//   mem_req/we/be/addr/wdata_op      unified memory request; mem_gnt/rvalid/rdata_ip back
// Modports: slave = arbiter side, master = core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                flush_ip;
    logic                if_req_ip;
    logic [ADDR_W-1:0]   if_addr_ip;
    logic                if_gnt_op;
    logic                if_rvalid_op;
    logic [DATA_W-1:0]   if_rdata_op;
    logic                if_stall_op;
    logic                lsu_req_ip;
    logic                lsu_we_ip;
    logic [DATA_W/8-1:0] lsu_be_ip;
    logic [ADDR_W-1:0]   lsu_addr_ip;
    logic [DATA_W-1:0]   lsu_wdata_ip;
    logic                lsu_gnt_op;
    logic                lsu_rvalid_op;
    logic [DATA_W-1:0]   lsu_rdata_op;
    logic                lsu_stall_op;
    logic                mem_req_op;
    logic                mem_we_op;
    logic [DATA_W/8-1:0] mem_be_op;
    logic [ADDR_W-1:0]   mem_addr_op;
    logic [DATA_W-1:0]   mem_wdata_op;
    logic                mem_gnt_ip;
    logic                mem_rvalid_ip;
    logic [DATA_W-1:0]   mem_rdata_ip;

    modport slave (
        input  flush_ip, if_req_ip, if_addr_ip,
               lsu_req_ip, lsu_we_ip, lsu_be_ip, lsu_addr_ip, lsu_wdata_ip,
               mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
        output if_gnt_op, if_rvalid_op, if_rdata_op, if_stall_op,
               lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op, lsu_stall_op,
               mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op
    );

    modport master (
        output flush_ip, if_req_ip, if_addr_ip,
               lsu_req_ip, lsu_we_ip, lsu_be_ip, lsu_addr_ip, lsu_wdata_ip,
               mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
        input  if_gnt_op, if_rvalid_op, if_rdata_op, if_stall_op,
               lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op, lsu_stall_op,
               mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding IF/LSU arbiter for the unified memory port
//
// Ports:
//   clk    core clock
//   reset  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave (fetch, load/store and memory signals)
// LSU wins ties unless IF has lost STARVE_LIMIT arbitrations in a row.
// Responses of fetches flushed while in flight are dropped.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int         BE_W     = DATA_W / 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RSP   = 2'd2;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    logic [1:0]        state;
    logic              owner_lsu;
    logic              drop;
    logic [3:0]        starve_cnt;
    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic accept, resp, arb_en, any_req, lsu_wins;
    logic if_owns, lsu_owns, if_rv, lsu_rv;

    assign accept   = (state == ST_REQ) && bus.mem_gnt_ip;
    // Responses outside RSP are stale (e.g. from before a reset) and ignored.
    assign resp     = (state == ST_RSP) && bus.mem_rvalid_ip;
    // Arbitrating on the response edge gives back-to-back requests.
    assign arb_en   = (state == ST_IDLE) || resp;
    assign any_req  = bus.if_req_ip || bus.lsu_req_ip;
    assign lsu_wins = bus.lsu_req_ip && !(bus.if_req_ip && (starve_cnt == LIMIT));
    assign if_owns  = (state != ST_IDLE) && !owner_lsu;
    assign lsu_owns = (state != ST_IDLE) && owner_lsu;
    // A flush in the response cycle itself also kills the fetch data.
    assign if_rv    = resp && !owner_lsu && !drop && !bus.flush_ip;
    assign lsu_rv   = resp && owner_lsu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner_lsu  <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // The request cannot be withdrawn once issued, so a flush only
            // marks the in-flight fetch for dropping.
            if (if_owns && bus.flush_ip) begin
                drop <= 1'b1;
            end
            case (state)
                ST_REQ: begin
                    if (accept) begin
                        mem_req <= 1'b0;
                        state   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (resp) begin
                        drop  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: ;
            endcase
            if (arb_en) begin
                if (!bus.if_req_ip || !lsu_wins) begin
                    starve_cnt <= 4'd0;
                end else if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
                if (any_req) begin
                    state     <= ST_REQ;
                    owner_lsu <= lsu_wins;
                    mem_req   <= 1'b1;
                    mem_we    <= lsu_wins && bus.lsu_we_ip;
                    mem_be    <= lsu_wins ? bus.lsu_be_ip : '1;
                    mem_addr  <= lsu_wins ? bus.lsu_addr_ip : bus.if_addr_ip;
                    mem_wdata <= lsu_wins ? bus.lsu_wdata_ip : '0;
                end
            end
        end
    end

    assign bus.mem_req_op    = mem_req;
    assign bus.mem_we_op     = mem_we;
    assign bus.mem_be_op     = mem_be;
    assign bus.mem_addr_op   = mem_addr;
    assign bus.mem_wdata_op  = mem_wdata;

    assign bus.if_gnt_op     = accept && !owner_lsu;
    assign bus.lsu_gnt_op    = accept && owner_lsu;
    assign bus.if_rvalid_op  = if_rv;
    assign bus.lsu_rvalid_op = lsu_rv;
    assign bus.if_rdata_op   = if_rv ? bus.mem_rdata_ip : '0;
    assign bus.lsu_rdata_op  = lsu_rv ? bus.mem_rdata_ip : '0;

    // Stalls are forced low while reset is held so every output reads zero.
    assign bus.if_stall_op  = reset &&
                              ((bus.if_req_ip && !if_rv) || (if_owns && !resp));
    assign bus.lsu_stall_op = reset &&
                              ((bus.lsu_req_ip && !lsu_rv) || (lsu_owns && !resp) ||
                               (bus.lsu_req_ip && if_owns));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_if_rv = 0, n_lsu_rv = 0;
    int gnt_dly = 0, rv_dly = 1;
    bit chk_order = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_lsu_q[$];
    bit          exp_gnt_q[$];   // 1 = LSU grant, 0 = IF grant

    logic obs_if_gnt, obs_if_rv, obs_lsu_gnt, obs_lsu_rv, obs_if_stall, obs_lsu_stall;
    logic obs_mem_req, obs_mem_we, obs_mem_rv, obs_any;
    logic [3:0]  obs_mem_be;
    logic [31:0] obs_mem_addr, obs_mem_wdata;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, score responses, then return just after the
    // next rising edge so the caller can drive the following cycle.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        obs_if_gnt    = bus.if_gnt_op;
        obs_if_rv     = bus.if_rvalid_op;
        obs_lsu_gnt   = bus.lsu_gnt_op;
        obs_lsu_rv    = bus.lsu_rvalid_op;
        obs_if_stall  = bus.if_stall_op;
        obs_lsu_stall = bus.lsu_stall_op;
        obs_mem_req   = bus.mem_req_op;
        obs_mem_we    = bus.mem_we_op;
        obs_mem_be    = bus.mem_be_op;
        obs_mem_addr  = bus.mem_addr_op;
        obs_mem_wdata = bus.mem_wdata_op;
        obs_mem_rv    = bus.mem_rvalid_ip;
        obs_any = |{bus.if_gnt_op, bus.if_rvalid_op, bus.if_rdata_op, bus.if_stall_op,
                    bus.lsu_gnt_op, bus.lsu_rvalid_op, bus.lsu_rdata_op, bus.lsu_stall_op,
                    bus.mem_req_op, bus.mem_we_op, bus.mem_be_op, bus.mem_addr_op,
                    bus.mem_wdata_op};
        if (chk_order && (obs_if_gnt || obs_lsu_gnt)) begin
            if (exp_gnt_q.size() == 0) check("extra_gnt", 1, 0);
            else check("gnt_order", obs_lsu_gnt, exp_gnt_q.pop_front());
        end
        if (obs_if_rv) begin
            n_if_rv++;
            if (exp_if_q.size() == 0) check("if_rv_unexpected", 1, 0);
            else begin
                e = exp_if_q.pop_front();
                check("if_rdata", bus.if_rdata_op, e);
            end
        end
        if (obs_lsu_rv) begin
            n_lsu_rv++;
            if (exp_lsu_q.size() == 0) check("lsu_rv_unexpected", 1, 0);
            else begin
                e = exp_lsu_q.pop_front();
                check("lsu_rdata", bus.lsu_rdata_op, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        int r0;
        bit got;
        exp_if_q.push_back(mem_f(addr));
        r0 = n_if_rv;
        bus.if_req_ip = 1'b1;
        bus.if_addr_ip = addr;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = obs_if_gnt;
        end
        bus.if_req_ip = 1'b0;
        check({tag, "_gnt"}, got, 1);
        for (int i = 0; i < 30 && n_if_rv == r0; i++) tick();
        check({tag, "_rv"}, n_if_rv - r0, 1);
    endtask

    // Memory model: gnt after gnt_dly cycles of mem_req, rvalid rv_dly cycles after accept.
    bit          m_acc, m_pend;
    int          m_wait, m_rvcnt;
    logic [31:0] m_resp;
    initial begin : mem_model
        bus.mem_gnt_ip = 1'b0;
        bus.mem_rvalid_ip = 1'b0;
        bus.mem_rdata_ip = '0;
        m_pend = 0; m_wait = 0; m_rvcnt = 0; m_resp = '0;
        forever begin
            @(negedge clk);
            m_acc = bus.mem_req_op && bus.mem_gnt_ip;
            if (m_acc) m_resp = bus.mem_we_op ? 32'h0 : mem_f(bus.mem_addr_op);
            @(posedge clk);
            #1;
            bus.mem_rvalid_ip = 1'b0;
            bus.mem_rdata_ip = '0;
            if (m_acc) begin
                m_pend = 1; m_rvcnt = rv_dly; m_wait = 0;
            end
            if (m_pend) begin
                m_rvcnt--;
                if (m_rvcnt == 0) begin
                    bus.mem_rvalid_ip = 1'b1;
                    bus.mem_rdata_ip = m_resp;
                    m_pend = 0;
                end
            end
            if (bus.mem_req_op) begin
                bus.mem_gnt_ip = (m_wait >= gnt_dly);
                m_wait++;
            end else begin
                bus.mem_gnt_ip = 1'b0;
                m_wait = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r0, nreq, gcount, rv_cyc, req_cyc;
        bit got;
        reset = 1'b0;
        bus.flush_ip = 1'b0;
        bus.if_req_ip = 1'b0;  bus.if_addr_ip = '0;
        bus.lsu_req_ip = 1'b0; bus.lsu_we_ip = 1'b0; bus.lsu_be_ip = '0;
        bus.lsu_addr_ip = '0;  bus.lsu_wdata_ip = '0;

        // reset state
        tick();
        check("reset_outputs", obs_any, 0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_outputs", obs_any, 0);

        // single fetch, slow memory
        gnt_dly = 2; rv_dly = 3;
        exp_if_q.push_back(32'hDEADBEEF);
        bus.if_req_ip = 1'b1; bus.if_addr_ip = 32'h100;
        r0 = n_if_rv; gcount = 0;
        for (int i = 0; i < 40 && n_if_rv == r0; i++) begin
            tick();
            if (obs_if_gnt) begin gcount++; bus.if_req_ip = 1'b0; end
            if (!obs_if_rv) check("if_stall_wait", obs_if_stall, 1);
            if (obs_mem_req) check("if_payload", {obs_mem_we, obs_mem_be, obs_mem_addr},
                                   {1'b0, 4'hF, 32'h100});
        end
        check("if_rv_count", n_if_rv - r0, 1);
        check("if_gnt_count", gcount, 1);
        check("if_stall_at_rv", obs_if_stall, 0);

        // starvation: both requesting, zero-wait memory
        gnt_dly = 0; rv_dly = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            repeat (4) begin
                exp_gnt_q.push_back(1'b1);
                exp_lsu_q.push_back(mem_f(32'h600));
            end
            exp_gnt_q.push_back(1'b0);
            exp_if_q.push_back(mem_f(32'h180));
        end
        chk_order = 1;
        bus.if_req_ip = 1'b1;  bus.if_addr_ip = 32'h180;
        bus.lsu_req_ip = 1'b1; bus.lsu_we_ip = 1'b0; bus.lsu_be_ip = 4'hF;
        bus.lsu_addr_ip = 32'h600;
        for (int i = 0; i < 200 && exp_gnt_q.size() > 0; i++) begin
            tick();
            check("starve_if_stall", obs_if_stall, !obs_if_rv);
            check("starve_lsu_stall", obs_lsu_stall, !obs_lsu_rv);
        end
        bus.if_req_ip = 1'b0; bus.lsu_req_ip = 1'b0;
        chk_order = 0;
        check("starve_gnts_left", exp_gnt_q.size(), 0);
        for (int i = 0; i < 20 && (exp_if_q.size() + exp_lsu_q.size()) > 0; i++) tick();
        check("starve_rv_left", exp_if_q.size() + exp_lsu_q.size(), 0);

        // store with payload held until gnt
        gnt_dly = 3; rv_dly = 2;
        exp_lsu_q.push_back(32'h0);
        bus.lsu_req_ip = 1'b1; bus.lsu_we_ip = 1'b1; bus.lsu_be_ip = 4'b0011;
        bus.lsu_addr_ip = 32'h2000; bus.lsu_wdata_ip = 32'h1234;
        r0 = n_lsu_rv; nreq = 0;
        for (int i = 0; i < 40 && n_lsu_rv == r0; i++) begin
            tick();
            if (obs_lsu_gnt) begin bus.lsu_req_ip = 1'b0; bus.lsu_we_ip = 1'b0; end
            if (obs_mem_req) begin
                nreq++;
                check("st_payload", {obs_mem_we, obs_mem_be, obs_mem_addr, obs_mem_wdata},
                      {1'b1, 4'b0011, 32'h2000, 32'h1234});
            end
        end
        check("st_rv_count", n_lsu_rv - r0, 1);
        check("st_req_cycles", nreq, 4);

        // flush while fetch is in RSP
        gnt_dly = 0; rv_dly = 4;
        bus.if_req_ip = 1'b1; bus.if_addr_ip = 32'h300;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = obs_if_gnt; end
        bus.if_req_ip = 1'b0;
        check("fl_gnt", got, 1);
        r0 = n_if_rv;
        bus.flush_ip = 1'b1;
        tick();
        bus.flush_ip = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = obs_mem_rv; end
        check("fl_mem_rv", got, 1);
        check("fl_dropped", n_if_rv - r0, 0);
        fetch(32'h104, "fl_next");

        // flush in the same cycle as the response
        gnt_dly = 0; rv_dly = 2;
        bus.if_req_ip = 1'b1; bus.if_addr_ip = 32'h308;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = obs_if_gnt; end
        bus.if_req_ip = 1'b0;
        tick();
        bus.flush_ip = 1'b1;
        tick();
        bus.flush_ip = 1'b0;
        check("fls_mem_rv", obs_mem_rv, 1);
        check("fls_if_rv", obs_if_rv, 0);
        fetch(32'h108, "fls_next");

        // reset while in RSP; stale response right after release
        gnt_dly = 0; rv_dly = 6;
        bus.if_req_ip = 1'b1; bus.if_addr_ip = 32'h400;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = obs_if_gnt; end
        bus.if_req_ip = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) begin
            tick();
            check("rst_outputs", obs_any, 0);
        end
        reset = 1'b1;
        tick();
        check("rst_rel_outputs", obs_any, 0);
        r0 = n_if_rv;
        tick();
        check("rst_stale_rv_seen", obs_mem_rv, 1);
        check("rst_stale_outputs", obs_any, 0);
        repeat (3) begin
            tick();
            check("rst_idle_outputs", obs_any, 0);
        end
        check("rst_no_if_rv", n_if_rv - r0, 0);
        fetch(32'h10C, "rst_next");

        // back-to-back LSU loads
        gnt_dly = 0; rv_dly = 2;
        exp_lsu_q.push_back(mem_f(32'h500));
        exp_lsu_q.push_back(mem_f(32'h504));
        bus.lsu_req_ip = 1'b1; bus.lsu_we_ip = 1'b0; bus.lsu_be_ip = 4'hF;
        bus.lsu_addr_ip = 32'h500;
        r0 = n_lsu_rv; gcount = 0; rv_cyc = -1; req_cyc = -1;
        for (int i = 0; i < 40 && (n_lsu_rv - r0) < 2; i++) begin
            tick();
            if (obs_lsu_gnt) begin
                gcount++;
                if (gcount == 1) bus.lsu_addr_ip = 32'h504;
                else bus.lsu_req_ip = 1'b0;
            end
            if (obs_lsu_rv && rv_cyc < 0) rv_cyc = cyc;
            else if (obs_mem_req && rv_cyc >= 0 && req_cyc < 0) req_cyc = cyc;
        end
        check("b2b_rv_count", n_lsu_rv - r0, 2);
        check("b2b_req_next_cycle", req_cyc - rv_cyc, 1);

        repeat (3) tick();
        check("final_queues_empty", exp_if_q.size() + exp_lsu_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the load/store unit (LSU) of the 5-stage core.
- Serialises requests with one outstanding transaction at a time.
- Gives LSU priority, with an anti-starvation override for IF.
- Drives per-requester stall outputs consumed by the pipeline stall logic. Drops the responses of fetches that are squashed by a branch/jump flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive LSU wins over a pending IF before IF is forced to win (range 1..15)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-low reset
- flush_ip  in  1  pipeline flush (taken branch/jump)
- if_req_ip  in  1  fetch request; held until if_gnt_op
- if_addr_ip  in  ADDR_W  fetch address
- if_gnt_op  out  1  fetch accepted by memory (1-cycle pulse)
- if_rvalid_op  out  1  fetch data valid (1-cycle pulse)
- if_rdata_op  out  DATA_W  fetch data
- if_stall_op  out  1  IF stage must stall
- lsu_req_ip  in  1  load/store request; held until lsu_gnt_op
- lsu_we_ip  in  1  1 = store
- lsu_be_ip  in  DATA_W/8  byte enables
- lsu_addr_ip  in  ADDR_W  data address
- lsu_wdata_ip  in  DATA_W  store data
- lsu_gnt_op  out  1  LSU accepted (1-cycle pulse)
- lsu_rvalid_op  out  1  LSU response valid (loads and stores)
- lsu_rdata_op  out  DATA_W  load data
- lsu_stall_op  out  1  LSU stage must stall
- mem_req_op  out  1  memory request
- mem_we_op  out  1  memory write enable
- mem_be_op  out  DATA_W/8  memory byte enables
- mem_addr_op  out  ADDR_W  memory address
- mem_wdata_op  out  DATA_W  memory write data
- mem_gnt_ip  in  1  memory accepts request when mem_req_op && mem_gnt_ip
- mem_rvalid_ip  in  1  response; exactly one per accepted request, earliest 1 cycle after accept
- mem_rdata_ip  in  DATA_W  response data

Behaviour:
- Reset (reset low, asynchronous): state IDLE, owner cleared, drop flag 0, starve counter 0. All outputs 0, including mem_* and rdata.
- FSM states are IDLE, REQ, RSP.
- IDLE:
  - Arbitrate on the registered clock edge.
  - Both requesting: LSU wins unless starve counter == STARVE_LIMIT, in which case IF wins.
  - Winner's address/we/be/wdata are latched into mem_* registers. mem_req_op goes high the next cycle; state -> REQ.
  - Non-LSU grants force mem_we_op = 0 and mem_be_op = all ones.
- REQ:
  - mem_req_op and payload held stable until mem_gnt_ip.
  - On the gnt cycle, pulse the owner's gnt output combinationally; mem_req_op drops next cycle; state -> RSP.
- RSP:
  - On mem_rvalid_ip, forward mem_rdata_ip and assert the owner's rvalid combinationally in the same cycle; state -> IDLE.
  - A new arbitration may occur on that same edge (back-to-back: rvalid cycle N, next mem_req_op cycle N+1).
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each LSU win while if_req_ip is high.
  - Clears on an IF win, or on any IDLE arbitration cycle with if_req_ip low.
- Flush:
  - flush_ip while IF owns the port in REQ or RSP sets the drop flag. The request is not withdrawn (memory protocol forbids dropping mem_req before gnt).
  - The matching response completes the FSM but suppresses if_rvalid_op. The drop flag clears on that response.
  - flush_ip in the same cycle as the response also suppresses it.
  - flush_ip has no effect on LSU transactions or in IDLE.
- Stalls (combinational):
  - if_stall_op = if_req_ip && !if_rvalid_op, or IF owns the port and the transaction is not yet complete.
  - lsu_stall_op follows the same rule for LSU.
  - lsu_stall_op also asserts when lsu_req_ip is high while IF owns the port.
- mem_rvalid_ip in IDLE/REQ is ignored (covers stale responses after reset).
- Reset mid-transaction: immediate return to IDLE; no gnt/rvalid emitted afterwards for the aborted request.

Test Plan:
- if_req_ip=1 only, addr 0x100; memory gnt 2 cycles after mem_req, rvalid 3 cycles after gnt with 0xDEADBEEF -> one if_gnt_op pulse, if_rvalid_op with 0xDEADBEEF, if_stall_op high every cycle until then.
- if_req_ip and lsu_req_ip both continuously high, STARVE_LIMIT=4, zero-wait memory -> grant order LSU, LSU, LSU, LSU, IF, repeating; never 5 consecutive LSU grants.
- LSU store addr 0x2000, be 4'b0011, wdata 0x1234 -> mem_we_op=1, mem_be_op=0011, mem_wdata_op=0x1234 stable until gnt; lsu_rvalid_op on response.
- IF fetch in RSP, flush_ip pulsed 1 cycle, then response arrives -> if_rvalid_op stays 0, FSM returns to IDLE, next fetch served normally.
- reset driven low while in RSP, mem_rvalid_ip arrives 1 cycle after reset release -> no rvalid output, all outputs 0, state IDLE.
- Back-to-back LSU loads with rvalid on cycle N -> second mem_req_op high on N+1.
